fft_in: RTL and testbench
=========================

Name: fft_in

Overview:
- Input-side loader for the burst FFT/IFFT core.
- Accepts one frame of complex samples on a valid/ready stream with index and last.
- Writes even-index samples to bank A and odd-index samples to bank B of the core's working RAM.
- Pulses fft_start once the frame is complete, then blocks further input until the core reports fft_cdone.

Parameters:
- DATA_WIDTH, 36, width of one complex sample ({re, im}).
- ADDR_WIDTH, 9, bank RAM address width. Frame holds at most 2^(ADDR_WIDTH+1) points.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- dft_length  input  ADDR_WIDTH+1  N-1, where N is points per frame. N is even, N ≥ 2. Sampled at frame start.
- s_axi_data  input  DATA_WIDTH  sample.
- s_axi_valid  input  1  sample valid.
- s_axi_last  input  1  final sample of frame.
- s_axi_ready  output  1  loader can accept a sample.
- oa_wr_en  output  1  bank A write strobe.
- oa_wr_addr  output  ADDR_WIDTH  bank A address.
- oa_wr_data  output  DATA_WIDTH  bank A data.
- ob_wr_en  output  1  bank B write strobe.
- ob_wr_addr  output  ADDR_WIDTH  bank B address.
- ob_wr_data  output  DATA_WIDTH  bank B data.
- fft_start  output  1  one-cycle pulse: frame loaded.
- fft_cdone  input  1  one-cycle pulse: core finished, banks free.
- frame_err  output  1  one-cycle pulse: s_axi_last misaligned with count.

Behaviour:
- Reset values:
  - All outputs 0.
  - State LOAD; in_index 0; latched length 0.
  - s_axi_ready rises on the first clk after reset release.
- States:
  - LOAD: s_axi_ready = 1.
  - START: s_axi_ready = 0; fft_start = 1 for exactly this cycle.
  - BUSY: s_axi_ready = 0; wait for fft_cdone.
- Handshake:
  - A transfer occurs when s_axi_valid & s_axi_ready are high on a clk edge.
  - s_axi_ready is registered and never depends combinationally on s_axi_valid.
- Length latch:
  - len_q <= dft_length on the first transfer of a frame (in_index == 0).
  - Changes to dft_length mid-frame are ignored.
- Write mapping, registered, latency 1 cycle after the transfer edge:
  - in_index[0] == 0: oa_wr_en = 1, oa_wr_addr = in_index[ADDR_WIDTH:1], oa_wr_data = s_axi_data.
  - in_index[0] == 1: same on port B.
  - Exactly one of oa_wr_en/ob_wr_en per transfer; never both.
  - Write data and address hold their last value when the strobe is 0.
- Counter:
  - in_index (ADDR_WIDTH+1 bits) increments per transfer.
  - Cleared to 0 on frame close.
- Frame close (LOAD -> START), on the transfer where in_index == len_q OR s_axi_last == 1, whichever comes first:
  - If only one of the two conditions is true, frame_err pulses in the same cycle as the final write strobe.
  - An early last closes a short frame. Unwritten bank entries are left untouched.
  - A missing last closes at N samples; the next sample starts a new frame after fft_cdone.
- Sequencing:
  - START lasts one cycle and coincides with the final write strobe.
  - Transition is START -> BUSY.
  - BUSY -> LOAD on fft_cdone; s_axi_ready = 1 the following cycle.
- fft_cdone in LOAD or START is ignored.
- Reset mid-frame: all state returns to reset values immediately. Partial bank contents are not cleared; no fft_start is issued.
- Throughput: one sample per clk in LOAD. Gaps in s_axi_valid are allowed anywhere.

Decomposition:
- Shared package fft_pkg holds:
  - state encoding typedef (LOAD, START, BUSY);
  - helper constant MAX_POINTS = 2^(ADDR_WIDTH+1);
  - the sample type {re, im} of DATA_WIDTH/2 each, shared with the output streamer.
- Single module; no sub-module warranted. Optional reusable bank_wr_demux (even/odd address split) only if the IFFT path needs the same mapping.

Test Plan:
- Nominal frame:
  - Stimulus: reset; dft_length = 7; 8 back-to-back samples 0x1..0x8, last on the 8th.
  - Response: bank A writes addr 0..3 = 1,3,5,7; bank B writes addr 0..3 = 2,4,6,8; fft_start pulses the cycle after the 8th transfer; s_axi_ready = 0 until fft_cdone, then 1 on the next cycle; frame_err never asserted.
- Valid gaps:
  - Stimulus: same frame with s_axi_valid low every other cycle.
  - Response: identical writes and addresses; fft_start exactly once.
- Early last:
  - Stimulus: dft_length = 7; last on the 4th sample.
  - Response: writes A0,B0,A1,B1 only; frame_err and fft_start pulse together; next frame after fft_cdone writes starting at A0.
- Missing last:
  - Stimulus: dft_length = 3; 4 samples, no last.
  - Response: frame closes after the 4th; frame_err = 1; fft_start = 1.
- Length change mid-frame:
  - Stimulus: dft_length 7 -> 3 after the 2nd sample.
  - Response: frame still takes 8 samples.
- Reset mid-frame:
  - Stimulus: assert rst after 3 samples of an 8-point frame.
  - Response: outputs 0 immediately; no fft_start; a fresh 8-point frame loads from A0 after release.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pkg : shared types and constants for the burst FFT/IFFT core   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fft_pkg;

   localparam int DEF_DATA_WIDTH = 36;
   localparam int DEF_ADDR_WIDTH = 9;
   localparam int MAX_POINTS     = 2 ** (DEF_ADDR_WIDTH + 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   // Complex sample as carried on the streams: real part in the upper half
   typedef struct packed {
      logic [DEF_DATA_WIDTH/2-1:0] re;
      logic [DEF_DATA_WIDTH/2-1:0] im;
   } sample_t;

endpackage
`default_nettype wire

// File: rtl/fft_in.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_in : frame loader, even samples to bank A, odd to bank B       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fft_in
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH:0]   dft_length,
   input  logic [DATA_WIDTH-1:0] s_axi_data,
   input  logic                  s_axi_valid,
   input  logic                  s_axi_last,
   output logic                  s_axi_ready,
   output logic                  oa_wr_en,
   output logic [ADDR_WIDTH-1:0] oa_wr_addr,
   output logic [DATA_WIDTH-1:0] oa_wr_data,
   output logic                  ob_wr_en,
   output logic [ADDR_WIDTH-1:0] ob_wr_addr,
   output logic [DATA_WIDTH-1:0] ob_wr_data,
   output logic                  fft_start,
   input  logic                  fft_cdone,
   output logic                  frame_err
);

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH:0]   in_index;
   logic [ADDR_WIDTH:0]   len_q;
   logic [ADDR_WIDTH:0]   len_eff;
   logic                  xfer;
   logic                  at_len;
   logic                  close;

   assign xfer    = s_axi_valid & s_axi_ready;
   // On the first sample the length register is still being loaded
   assign len_eff = (in_index == '0) ? dft_length : len_q;
   assign at_len  = (in_index == len_eff);
   assign close   = xfer & (at_len | s_axi_last);

   assign fft_start = (state_q == START);

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (close)     state_d = START;
         START:                  state_d = BUSY;
         BUSY:    if (fft_cdone) state_d = LOAD;
         default:                state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD;
         s_axi_ready <= 1'b0;
         in_index    <= '0;
         len_q       <= '0;
         frame_err   <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_axi_ready <= (state_d == LOAD);
         frame_err   <= xfer & (at_len ^ s_axi_last);
         if (xfer) begin
            if (in_index == '0) len_q <= dft_length;
            in_index <= close ? '0 : in_index + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oa_wr_en   <= 1'b0;
         oa_wr_addr <= '0;
         oa_wr_data <= '0;
         ob_wr_en   <= 1'b0;
         ob_wr_addr <= '0;
         ob_wr_data <= '0;
      end else begin
         oa_wr_en <= xfer & ~in_index[0];
         ob_wr_en <= xfer &  in_index[0];
         if (xfer & ~in_index[0]) begin
            oa_wr_addr <= in_index[ADDR_WIDTH:1];
            oa_wr_data <= s_axi_data;
         end
         if (xfer & in_index[0]) begin
            ob_wr_addr <= in_index[ADDR_WIDTH:1];
            ob_wr_data <= s_axi_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_in.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft_in : directed self-checking bench for fft_in                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fft_in;

   localparam int DW = 36;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW:0]   dft_length = '0;
   logic [DW-1:0] s_axi_data = '0;
   logic          s_axi_valid = 1'b0;
   logic          s_axi_last = 1'b0;
   logic          s_axi_ready;
   logic          oa_wr_en, ob_wr_en;
   logic [AW-1:0] oa_wr_addr, ob_wr_addr;
   logic [DW-1:0] oa_wr_data, ob_wr_data;
   logic          fft_start;
   logic          fft_cdone = 1'b0;
   logic          frame_err;

   int tests = 0;
   int fails = 0;

   int a_addr[$], b_addr[$];
   logic [DW-1:0] a_data[$], b_data[$];
   int n_start = 0, n_err = 0, n_both = 0;

   fft_in #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .dft_length(dft_length),
      .s_axi_data(s_axi_data), .s_axi_valid(s_axi_valid), .s_axi_last(s_axi_last),
      .s_axi_ready(s_axi_ready),
      .oa_wr_en(oa_wr_en), .oa_wr_addr(oa_wr_addr), .oa_wr_data(oa_wr_data),
      .ob_wr_en(ob_wr_en), .ob_wr_addr(ob_wr_addr), .ob_wr_data(ob_wr_data),
      .fft_start(fft_start), .fft_cdone(fft_cdone), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Write/pulse recorder sampled mid-cycle
   always @(negedge clk) begin
      if (oa_wr_en) begin a_addr.push_back(int'(oa_wr_addr)); a_data.push_back(oa_wr_data); end
      if (ob_wr_en) begin b_addr.push_back(int'(ob_wr_addr)); b_data.push_back(ob_wr_data); end
      if (oa_wr_en && ob_wr_en) n_both++;
      if (fft_start) n_start++;
      if (frame_err) n_err++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the transfer edge
   task automatic send(input logic [DW-1:0] d, input logic l);
      int budget = 0;
      s_axi_data  = d;
      s_axi_last  = l;
      s_axi_valid = 1'b1;
      while (!s_axi_ready && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!s_axi_ready) check("ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      s_axi_valid = 1'b0;
      s_axi_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic cdone_pulse(input string tag);
      fft_cdone = 1'b1;
      @(posedge clk); #1;
      fft_cdone = 1'b0;
      check({tag, "_ready_after_cdone"}, 64'(s_axi_ready), 64'd1);
   endtask

   // Checks k entries per bank from given bases: A data first+2i, B data first+2i+1
   task automatic check_banks(input string tag, input int ba, input int bb, input int k,
                              input logic [DW-1:0] first);
      check({tag, "_a_count"}, 64'(a_addr.size() - ba), 64'(k));
      check({tag, "_b_count"}, 64'(b_addr.size() - bb), 64'(k));
      for (int i = 0; i < k; i++) begin
         if (ba + i < a_addr.size()) begin
            check($sformatf("%s_a%0d_addr", tag, i), 64'(a_addr[ba+i]), 64'(i));
            check($sformatf("%s_a%0d_data", tag, i), 64'(a_data[ba+i]), 64'(first + DW'(2*i)));
         end
         if (bb + i < b_addr.size()) begin
            check($sformatf("%s_b%0d_addr", tag, i), 64'(b_addr[bb+i]), 64'(i));
            check($sformatf("%s_b%0d_data", tag, i), 64'(b_data[bb+i]), 64'(first + DW'(2*i+1)));
         end
      end
   endtask

   initial begin
      int ba, bb, s0, e0;

      // Reset state
      #2;
      check("rst_ready", 64'(s_axi_ready), 64'd0);
      check("rst_outs", 64'({oa_wr_en, ob_wr_en, fft_start, frame_err}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("ready_low_before_edge", 64'(s_axi_ready), 64'd0);
      @(posedge clk); #1;
      check("ready_after_release", 64'(s_axi_ready), 64'd1);

      // Nominal 8-point frame
      dft_length = 10'd7;
      ba = a_addr.size(); bb = b_addr.size(); s0 = n_start; e0 = n_err;
      for (int i = 1; i <= 8; i++) send(DW'(i), i == 8);
      check("nom_start", 64'(fft_start), 64'd1);
      check("nom_ready_low", 64'(s_axi_ready), 64'd0);
      check("nom_err", 64'(frame_err), 64'd0);
      s_axi_valid = 1'b1; s_axi_data = DW'(36'h99);
      idle(4);
      check("nom_busy_ready", 64'(s_axi_ready), 64'd0);
      check("nom_start_once", 64'(n_start - s0), 64'd1);
      check("nom_err_none", 64'(n_err - e0), 64'd0);
      check_banks("nom", ba, bb, 4, DW'(1));
      s_axi_valid = 1'b0;
      cdone_pulse("nom");

      // Same frame with gaps; stray cdone in LOAD is ignored
      fft_cdone = 1'b1; idle(1); fft_cdone = 1'b0;
      check("gap_cdone_in_load", 64'(s_axi_ready), 64'd1);
      ba = a_addr.size(); bb = b_addr.size(); s0 = n_start; e0 = n_err;
      for (int i = 1; i <= 8; i++) begin
         send(DW'(i), i == 8);
         if (i != 8) idle(1);
      end
      check("gap_start", 64'(fft_start), 64'd1);
      idle(3);
      check("gap_start_once", 64'(n_start - s0), 64'd1);
      check("gap_err_none", 64'(n_err - e0), 64'd0);
      check_banks("gap", ba, bb, 4, DW'(1));
      cdone_pulse("gap");

      // Early last on the 4th sample
      ba = a_addr.size(); bb = b_addr.size(); s0 = n_start;
      for (int i = 1; i <= 4; i++) send(DW'(36'h20 + i - 1), i == 4);
      check("early_start", 64'(fft_start), 64'd1);
      check("early_err", 64'(frame_err), 64'd1);
      idle(2);
      check("early_err_pulse", 64'(frame_err), 64'd0);
      check_banks("early", ba, bb, 2, DW'(36'h20));
      cdone_pulse("early");

      // Minimum frame N=2 starts back at A0
      dft_length = 10'd1;
      ba = a_addr.size(); bb = b_addr.size();
      send(DW'(36'h40), 1'b0);
      send(DW'(36'h41), 1'b1);
      check("n2_start", 64'(fft_start), 64'd1);
      check("n2_err", 64'(frame_err), 64'd0);
      idle(1);
      check_banks("n2", ba, bb, 1, DW'(36'h40));
      cdone_pulse("n2");

      // Missing last: closes at N=4
      dft_length = 10'd3;
      ba = a_addr.size(); bb = b_addr.size();
      for (int i = 0; i < 3; i++) send(DW'(36'h50 + i), 1'b0);
      check("miss_no_start_yet", 64'(fft_start), 64'd0);
      send(DW'(36'h53), 1'b0);
      check("miss_start", 64'(fft_start), 64'd1);
      check("miss_err", 64'(frame_err), 64'd1);
      idle(1);
      check_banks("miss", ba, bb, 2, DW'(36'h50));
      cdone_pulse("miss");

      // Length change mid-frame is ignored
      dft_length = 10'd7;
      s0 = n_start;
      for (int i = 1; i <= 8; i++) begin
         send(DW'(i), i == 8);
         if (i == 2) dft_length = 10'd3;
         if (i == 4) check("lenchg_no_close_at_4", 64'(fft_start), 64'd0);
      end
      check("lenchg_start", 64'(fft_start), 64'd1);
      check("lenchg_err", 64'(frame_err), 64'd0);
      idle(1);
      check("lenchg_start_once", 64'(n_start - s0), 64'd1);
      cdone_pulse("lenchg");

      // Reset mid-frame
      dft_length = 10'd7;
      s0 = n_start;
      for (int i = 1; i <= 3; i++) send(DW'(i), 1'b0);
      rst = 1'b1;
      #1;
      check("mrst_outs", 64'({s_axi_ready, oa_wr_en, ob_wr_en, fft_start, frame_err}), 64'd0);
      check("mrst_data", 64'(oa_wr_data), 64'd0);
      idle(2);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mrst_ready", 64'(s_axi_ready), 64'd1);
      check("mrst_no_start", 64'(n_start - s0), 64'd0);
      ba = a_addr.size(); bb = b_addr.size();
      for (int i = 0; i < 8; i++) send(DW'(36'h60 + i), i == 7);
      check("mrst_start", 64'(fft_start), 64'd1);
      idle(1);
      check_banks("mrst", ba, bb, 4, DW'(36'h60));
      check("never_both_banks", 64'(n_both), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
